uart_txrx: RTL and testbench

Full-duplex 8N1 UART transceiver: an independent transmit engine and receive engine share one clock and one synchronous reset. It sits between on-chip logic, which uses a byte/strobe handshake, and the external serial TX and RX pins. Baud rate is fixed at elaboration by a clocks-per-bit parameter. Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_engine.sv | 99 +++++++++
 rtl/uart_tx_engine.sv | 87 ++++++++
 rtl/uart_txrx.sv | 39 +++
 tb/tb_uart_txrx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmit and receive engines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_engine.sv
// 8N1 deserialiser with 2-flop input synchroniser and mid-bit sampling.
// Latency: rx_dv pulses one cycle after the stop-bit mid-sample (~9.5 bit-times after start edge).
// Backpressure: none; rx_byte holds until the next good frame, framing errors are dropped.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DATA_BITS - 1);

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    byte_nxt;
  logic          dv_nxt;
  logic          meta, sync;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= serial;
      sync <= meta;
    end
  end

  // State register plus counter, index, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_dv   <= 1'b0;
      rx_byte <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      rx_dv   <= dv_nxt;
      rx_byte <= byte_nxt;
    end
  end

  // Next-state: half a bit to mid-start, then one full bit between samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_end ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          shreg_nxt = {sync, shreg[7:1]};
          if (idx == IDX_MAX) state_nxt = RX_STOP;
          else                idx_nxt   = idx + 1'b1;
        end
      end
      RX_STOP: if (bit_end) state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Outputs: publish the byte only when the stop sample is high.
  always_comb begin
    dv_nxt   = (state == RX_STOP) && bit_end && sync;
    byte_nxt = dv_nxt ? shreg : rx_byte;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
// Latency: line goes low the cycle after the strobe is captured; done pulses 10 bit-times later.
// Backpressure: strobes arriving while active are dropped; the done cycle is idle and accepts one.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    data, data_nxt;
  logic          done_nxt;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // State register plus bit counter, bit index, latched byte and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      data    <= '0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      data    <= data_nxt;
      tx_done <= done_nxt;
    end
  end

  // Next-state: walk START -> DATA x8 -> STOP, one bit-time per step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_end ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    data_nxt  = data;
    case (state)
      TX_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (tx_dv) begin
          data_nxt  = tx_byte;
          state_nxt = TX_START;
        end
      end
      TX_START: if (bit_end) state_nxt = TX_DATA;
      TX_DATA: begin
        if (bit_end) begin
          if (idx == IDX_MAX) state_nxt = TX_STOP;
          else                idx_nxt   = idx + 1'b1;
        end
      end
      TX_STOP: if (bit_end) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Outputs decoded from state; done is armed on the last stop-bit cycle.
  always_comb begin
    tx_active = (state != TX_IDLE);
    done_nxt  = (state == TX_STOP) && bit_end;
    case (state)
      TX_START: tx_serial = 1'b0;
      TX_DATA:  tx_serial = data[idx];
      default:  tx_serial = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmit and receive engines on one clock.
// Latency: see the engines; TX and RX run concurrently with no shared state.
// Backpressure: TX drops strobes while active; RX has none.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  uart_tx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .tx_dv     (i_Tx_DV),
    .tx_byte   (i_Tx_Byte),
    .tx_active (o_Tx_Active),
    .tx_serial (o_Tx_Serial),
    .tx_done   (o_Tx_Done)
  );

  uart_rx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .serial  (i_Rx_Serial),
    .rx_dv   (o_Rx_DV),
    .rx_byte (o_Rx_Byte)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: TX waveform, RX vectors, loopback and reset abort.
// Uses a short bit time so the whole run stays well inside the cycle budget.
module tb_uart_txrx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_drv;
  logic       loop;
  logic       rx_line;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [7:0] last_dv_byte = 8'h00;
  logic [7:0] model_byte = 8'h00;

  typedef struct {
    logic [7:0] b;
    int         start_len;
    int         bit_len;
    bit         stop_val;
    int         exp_dv;
    logic [7:0] exp_byte;
  } rx_vec_t;

  rx_vec_t vecs[6];

  assign rx_line = loop ? tx_serial : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Active (tx_active),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Done   (tx_done),
    .i_Rx_Serial (rx_line),
    .o_Rx_DV     (rx_dv),
    .o_Rx_Byte   (rx_byte)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Free-running cycle count for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Count DV and done pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      dv_cnt       = dv_cnt + 1;
      last_dv_byte = rx_byte;
    end
    if (tx_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expects tx_dv to be presented in the current cycle; follows one whole frame.
  // A mid-frame strobe with a different byte must be ignored.
  task automatic tx_observe(input logic [7:0] b, input bit restrobe, input logic [7:0] nb);
    logic [9:0] frame;
    int bad[10];
    bit act_bad;
    bit early_done;
    frame = {1'b1, b, 1'b0};
    act_bad = 1'b0;
    early_done = 1'b0;
    for (int i = 0; i < 10; i++) bad[i] = 0;
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(negedge clk);
      if (tx_serial !== frame[(k - 1) / CPB]) bad[(k - 1) / CPB]++;
      if (tx_active !== 1'b1) act_bad = 1'b1;
      if (tx_done !== 1'b0) early_done = 1'b1;
      if (k == 1) tx_dv = 1'b0;
      if (k == 5 * CPB) begin
        tx_dv = 1'b1;
        tx_byte = ~b;
      end
      if (k == 5 * CPB + 1) tx_dv = 1'b0;
    end
    @(negedge clk);
    check("tx_done_pulse", int'(tx_done), 1);
    check("tx_active_end", int'(tx_active), 0);
    last_done_cyc = cyc;
    if (restrobe) begin
      tx_dv = 1'b1;
      tx_byte = nb;
    end
    for (int i = 0; i < 10; i++) check($sformatf("tx_bit%0d_badcycles", i), bad[i], 0);
    check("tx_active_during_frame", int'(act_bad), 0);
    check("tx_done_early", int'(early_done), 0);
  endtask

  // Drive one RX frame with the given start and bit lengths, starting now.
  task automatic rx_send(input logic [7:0] b, input int start_len, input int bit_len,
                         input bit stop_val);
    rx_drv = 1'b0;
    repeat (start_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bit_len) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (bit_len) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic rx_case(input rx_vec_t v, input string tag);
    int base;
    @(negedge clk);
    #1;
    base = dv_cnt;
    rx_send(v.b, v.start_len, v.bit_len, v.stop_val);
    #1;
    check({tag, "_dv_by_stop_end"}, dv_cnt - base, v.exp_dv);
    check({tag, "_byte_by_stop_end"}, int'(rx_byte), int'(v.exp_byte));
    repeat (2 * CPB) @(negedge clk);
    #1;
    check({tag, "_dv_total"}, dv_cnt - base, v.exp_dv);
  endtask

  initial begin
    int d1;
    int base_dv;
    int base_done;
    rx_vec_t rv;
    logic [7:0] rb;

    rst = 1'b1;
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    rx_drv = 1'b1;
    loop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_serial", int'(tx_serial), 1);
    check("reset_tx_active", int'(tx_active), 0);
    check("reset_tx_done", int'(tx_done), 0);
    check("reset_rx_dv", int'(rx_dv), 0);
    check("reset_rx_byte", int'(rx_byte), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 0xAB.
    tx_dv = 1'b1;
    tx_byte = 8'hAB;
    tx_observe(8'hAB, 1'b0, 8'h00);
    repeat (20) @(negedge clk);

    // Back-to-back 0x00 then 0xFF, second strobe in the done cycle.
    tx_dv = 1'b1;
    tx_byte = 8'h00;
    tx_observe(8'h00, 1'b1, 8'hFF);
    d1 = last_done_cyc;
    tx_observe(8'hFF, 1'b0, 8'h00);
    check("b2b_done_spacing", last_done_cyc - d1, 10 * CPB + 1);
    repeat (20) @(negedge clk);

    // RX vector table: +10% start / -1% bits, framing errors, edge bytes.
    vecs[0] = '{8'h3F, CPB + CPB / 10, CPB - CPB / 100, 1'b1, 1, 8'h3F};
    vecs[1] = '{8'hA5, CPB,            CPB - 1,         1'b0, 0, 8'h3F};
    vecs[2] = '{8'h00, CPB,            CPB,             1'b1, 1, 8'h00};
    vecs[3] = '{8'hFF, CPB + CPB / 10, CPB - CPB / 100, 1'b1, 1, 8'hFF};
    vecs[4] = '{8'h80, CPB,            CPB - CPB / 100, 1'b1, 1, 8'h80};
    vecs[5] = '{8'h01, CPB,            CPB - 1,         1'b0, 0, 8'h80};
    for (int i = 0; i < 6; i++) rx_case(vecs[i], $sformatf("rxvec%0d", i));
    model_byte = 8'h80;

    // False start: short low pulse well under half a bit.
    @(negedge clk);
    #1;
    base_dv = dv_cnt;
    rx_drv = 1'b0;
    repeat (CPB / 5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #1;
    check("false_start_dv", dv_cnt - base_dv, 0);
    check("false_start_byte", int'(rx_byte), int'(model_byte));

    // Randomised RX frames inside the tolerance window.
    for (int i = 0; i < 6; i++) begin
      rv.b = 8'($urandom_range(0, 255));
      rv.stop_val = ($urandom_range(0, 3) != 0);
      if (rv.stop_val) begin
        rv.start_len = $urandom_range(CPB, CPB + CPB / 10);
        rv.bit_len = $urandom_range(CPB - CPB / 100, CPB);
        model_byte = rv.b;
      end else begin
        rv.start_len = CPB;
        rv.bit_len = CPB - 1;
      end
      rv.exp_dv = rv.stop_val ? 1 : 0;
      rv.exp_byte = model_byte;
      rx_case(rv, $sformatf("rxrand%0d", i));
    end

    // Loopback of random bytes: TX waveform and RX byte both checked.
    loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      @(negedge clk);
      #1;
      base_dv = dv_cnt;
      tx_dv = 1'b1;
      tx_byte = rb;
      tx_observe(rb, 1'b0, 8'h00);
      repeat ($urandom_range(5, 30)) @(negedge clk);
      #1;
      check($sformatf("loop%0d_dv", i), dv_cnt - base_dv, 1);
      check($sformatf("loop%0d_byte", i), int'(last_dv_byte), int'(rb));
    end
    loop = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during TX data bit 3 and RX data bit 3.
    #1;
    base_dv = dv_cnt;
    base_done = done_cnt;
    tx_dv = 1'b1;
    tx_byte = 8'hC3;
    fork
      rx_send(8'hF0, CPB, CPB, 1'b1);
      begin
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (4 * CPB + 7 * CPB / 10 - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_serial", int'(tx_serial), 1);
        check("abort_tx_active", int'(tx_active), 0);
        rst = 1'b0;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_no_dv", dv_cnt - base_dv, 0);
    check("abort_rx_byte_cleared", int'(rx_byte), 0);

    // Loopback 0x55 after the abort.
    loop = 1'b1;
    @(negedge clk);
    #1;
    base_dv = dv_cnt;
    tx_dv = 1'b1;
    tx_byte = 8'h55;
    tx_observe(8'h55, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    #1;
    check("post_abort_dv", dv_cnt - base_dv, 1);
    check("post_abort_byte", int'(last_dv_byte), 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
